// File: rtl/clk_div_pkg.sv
// clk_div_pkg: shared types and helpers for the programmable clock divider
// Contents: state_t FSM encoding, DIV_MIN, clamp_div() and hi_len() helpers.
package clk_div_pkg;
    typedef enum logic {IDLE, RUN} state_t;
    localparam int DIV_MIN = 2;
    function automatic logic [31:0] clamp_div(input logic [31:0] d);
        return (d < 32'(DIV_MIN)) ? 32'(DIV_MIN) : d;
    endfunction
    function automatic logic [31:0] hi_len(input logic [31:0] n);
        return n - (n >> 1);
    endfunction
endpackage

// File: rtl/clk_div_if.sv
// clk_div_if: valid/ready divisor configuration port
// Signals: cfg_valid (divisor offered), cfg_div (requested divisor), cfg_ready (controller accepts).
// Modports: master drives the request, slave is the controller side.
interface clk_div_if #(parameter int DIV_W = 8);
    logic             cfg_valid;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_ready;
    modport master(output cfg_valid, cfg_div, input cfg_ready);
    modport slave(input cfg_valid, cfg_div, output cfg_ready);
endinterface

// File: rtl/clk_div_phase.sv
// clk_div_phase: period counter, wrap detect and high/low phase compare
// Ports: clk_i, rst, div (divisor in effect), run (FSM in RUN), restart (IDLE->RUN this edge),
//        cnt_wrap (last cycle of the period), clk_next (clk_o value for the next cycle).
module clk_div_phase
    import clk_div_pkg::*;
#(
    parameter int DIV_W = 8
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic [DIV_W-1:0] div,
    input  logic             run,
    input  logic             restart,
    output logic             cnt_wrap,
    output logic             clk_next
);
    logic [DIV_W-1:0] cnt_q, cnt_d;
    assign cnt_wrap = run && cnt_q == div - 1'b1;
    assign cnt_d    = (run && !cnt_wrap) ? cnt_q + 1'b1 : '0;
    // A new period always starts at cnt 0, which is high for every divisor, so a
    // divisor swapped in at the boundary never affects this compare.
    assign clk_next = (run || restart) && 32'(cnt_d) < hi_len(32'(div));
    always_ff @(posedge clk_i) begin
        if (rst) cnt_q <= '0;
        else     cnt_q <= cnt_d;
    end
endmodule

// File: rtl/clk_div_ctrl.sv
// clk_div_ctrl: runtime-programmable integer clock divider with boundary-aligned ratio updates
// Ports: clk_i, rst (sync, active-high), en_i (run request), cfg (clk_div_if slave: divisor
//        handshake), clk_o (divided clock), running_o (state is RUN), div_o (divisor in effect),
//        tick_o (period-start pulse, only when CLK_DIV_CTRL_TICK_EN is defined).
module clk_div_ctrl
    import clk_div_pkg::*;
#(
    parameter int DIV_W       = 8,
    parameter int DEFAULT_DIV = 3
) (
    input  logic             clk_i,
    input  logic             rst,
    input  logic             en_i,
    clk_div_if.slave         cfg,
    output logic             clk_o,
    output logic             running_o,
    output logic [DIV_W-1:0] div_o
`ifdef CLK_DIV_CTRL_TICK_EN
    ,
    output logic             tick_o
`endif
);
    state_t           state_q;
    logic             clk_q, running_q, pend_q;
    logic [DIV_W-1:0] div_q, pend_div_q, cfg_div_c;
    logic             run, restart, run_nxt, xfer, cnt_wrap, clk_next;
    assign run       = state_q == RUN;
    assign restart   = !run && en_i;
    // Leaving RUN only happens at a period boundary, so the last period always completes.
    assign run_nxt   = run ? !(cnt_wrap && !en_i) : en_i;
    assign xfer      = cfg.cfg_valid && !pend_q;
    assign cfg_div_c = DIV_W'(clamp_div(32'(cfg.cfg_div)));
    assign cfg.cfg_ready = !pend_q;
    assign clk_o     = clk_q;
    assign running_o = running_q;
    assign div_o     = div_q;
    clk_div_phase #(.DIV_W(DIV_W)) u_phase (
        .clk_i    (clk_i),
        .rst      (rst),
        .div      (div_q),
        .run      (run),
        .restart  (restart),
        .cnt_wrap (cnt_wrap),
        .clk_next (clk_next)
    );
`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_q;
    assign tick_o = tick_q;
    always_ff @(posedge clk_i) begin
        if (rst) tick_q <= 1'b0;
        else     tick_q <= run_nxt && (restart || cnt_wrap);
    end
`endif
    always_ff @(posedge clk_i) begin
        if (rst) begin
            state_q    <= IDLE;
            clk_q      <= 1'b0;
            running_q  <= 1'b0;
            div_q      <= DIV_W'(DEFAULT_DIV);
            pend_q     <= 1'b0;
            pend_div_q <= '0;
        end else begin
            state_q   <= run_nxt ? RUN : IDLE;
            running_q <= run_nxt;
            clk_q     <= run_nxt && clk_next;
            case (state_q)
                IDLE: if (xfer) div_q <= cfg_div_c;
                RUN: begin
                    // pend_q blocks xfer, so apply and capture never collide; a capture on
                    // the wrap cycle therefore waits for the following boundary.
                    if (cnt_wrap && pend_q) begin
                        div_q  <= pend_div_q;
                        pend_q <= 1'b0;
                    end
                    if (xfer) begin
                        pend_q     <= 1'b1;
                        pend_div_q <= cfg_div_c;
                    end
                end
            endcase
        end
    end
endmodule

// File: tb/tb_clk_div_ctrl.sv
// tb_clk_div_ctrl: randomized self-checking bench against a period-queue reference model
module tb_clk_div_ctrl;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en  = 1'b0;
    logic       clk_o, running_o;
    logic [7:0] div_o;
    int         n_tests = 0;
    int         n_fail  = 0;
    clk_div_if #(.DIV_W(8)) cfg_if ();
`ifdef CLK_DIV_CTRL_TICK_EN
    logic tick_o;
`endif
    clk_div_ctrl #(.DIV_W(8), .DEFAULT_DIV(3)) dut (
        .clk_i     (clk),
        .rst       (rst),
        .en_i      (en),
        .cfg       (cfg_if),
        .clk_o     (clk_o),
        .running_o (running_o),
        .div_o     (div_o)
`ifdef CLK_DIV_CTRL_TICK_EN
        ,
        .tick_o    (tick_o)
`endif
    );
    always #5 clk = ~clk;

    // Reference model: a period is a queue of output levels; the boundary is reached
    // when the queue runs dry.
    bit m_run, m_pend, m_clk, m_tick;
    int m_div, m_pend_div;
    bit per_q[$];

    function automatic int clampd(input int d);
        return d < 2 ? 2 : d;
    endfunction

    function void start_period();
        per_q.delete();
        for (int i = 0; i < m_div; i++) per_q.push_back(i < m_div - m_div / 2);
        m_clk  = per_q.pop_front();
        m_tick = 1'b1;
    endfunction

    function void model_step();
        bit xfer;
        int cd;
        if (rst) begin
            m_run = 0; m_pend = 0; m_clk = 0; m_tick = 0; m_div = 3; m_pend_div = 0;
            per_q.delete();
            return;
        end
        xfer   = cfg_if.cfg_valid && !m_pend;
        cd     = clampd(int'(cfg_if.cfg_div));
        m_tick = 1'b0;
        if (!m_run) begin
            if (xfer) m_div = cd;
            if (en) begin
                m_run = 1;
                start_period();
            end else m_clk = 0;
        end else if (per_q.size() != 0) begin
            m_clk = per_q.pop_front();
            if (xfer) begin m_pend = 1; m_pend_div = cd; end
        end else begin
            if (m_pend) begin m_div = m_pend_div; m_pend = 0; end
            else if (xfer) begin m_pend = 1; m_pend_div = cd; end
            if (en) start_period();
            else begin m_run = 0; m_clk = 0; end
        end
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0d exp=%0d at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic cycle(input logic r, input logic e, input logic v, input logic [7:0] d);
        @(negedge clk);
        rst = r; en = e; cfg_if.cfg_valid = v; cfg_if.cfg_div = d;
        @(posedge clk);
        model_step();
        #1;
        check("clk_o", 32'(clk_o), 32'(m_clk));
        check("running_o", 32'(running_o), 32'(m_run));
        check("div_o", 32'(div_o), 32'(m_div));
        check("cfg_ready", 32'(cfg_if.cfg_ready), 32'(!m_pend));
`ifdef CLK_DIV_CTRL_TICK_EN
        check("tick_o", 32'(tick_o), 32'(m_tick));
`endif
    endtask

    task automatic repeat_cycle(input int n, input logic e, input logic v, input logic [7:0] d);
        for (int i = 0; i < n; i++) cycle(1'b0, e, v, d);
    endtask

    task automatic seg(input int n, input int en_flip, input int vpct, input int rst_rate);
        logic       r, e, v;
        logic [7:0] d;
        e = en;
        for (int i = 0; i < n; i++) begin
            r = rst_rate != 0 && $urandom_range(rst_rate - 1) == 0;
            if ($urandom_range(en_flip - 1) == 0) e = !e;
            v = $urandom_range(99) < vpct;
            d = ($urandom_range(7) == 0) ? 8'($urandom_range(255)) : 8'($urandom_range(6));
            cycle(r, e, v, d);
        end
    endtask

    initial begin
        cfg_if.cfg_valid = 1'b0;
        cfg_if.cfg_div   = '0;
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        cycle(1'b1, 1'b0, 1'b0, 8'd0);
        check("rst_div_const", 32'(div_o), 32'd3);
        check("rst_clk_const", 32'(clk_o), 32'd0);
        repeat_cycle(12, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'd4);
        repeat_cycle(12, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'd0);
        repeat_cycle(10, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'd255);
        repeat_cycle(20, 1'b1, 1'b1, 8'd4);
        repeat_cycle(520, 1'b1, 1'b0, 8'd0);
        repeat_cycle(2, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b0, 8'd0);
        repeat_cycle(10, 1'b0, 1'b0, 8'd0);
        cycle(1'b0, 1'b0, 1'b1, 8'd1);
        repeat_cycle(8, 1'b1, 1'b0, 8'd0);
        cycle(1'b0, 1'b1, 1'b1, 8'd9);
        repeat_cycle(2, 1'b1, 1'b1, 8'd5);
        cycle(1'b1, 1'b1, 1'b0, 8'd0);
        repeat_cycle(10, 1'b1, 1'b0, 8'd0);
        seg(2000, 40, 10, 0);
        seg(2000, 12, 30, 0);
        seg(2500, 60, 50, 700);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
